dense_lane_engine: RTL

Parametrised multi-lane engine for one dense (fully connected) layer: out[m] = requant(bias[m] + Σk w[m][k]·in[k]). Computes LANES outputs in parallel per pass, with arithmetic-shift requantisation, saturation and optional fused ReLU. Sits under the layer sequencer and replaces its separate bias-init and single-lane MAC loops. Reads input, weight and bias scratchpads and writes results back one output per cycle.

---
 rtl/nn_pkg.sv | 28 ++
 rtl/requant_sat_relu.sv | 35 +++
 rtl/dense_lane_engine.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
`default_nettype none
// nn_pkg -- shared FSM states, layer-type codes and default widths for the NN layer datapath.
// rev 1.0
package nn_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_ACC_BITS   = 24;
  localparam int DEF_LANES      = 4;
  localparam int DEF_ADDR_BITS  = 16;
  localparam int DEF_SIZE_BITS  = 10;
  localparam int DEF_SHIFT_BITS = 5;

  localparam logic [1:0] DENSE  = 2'd0;
  localparam logic [1:0] RELU   = 2'd1;
  localparam logic [1:0] MOVE   = 2'd2;
  localparam logic [1:0] OUTPUT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BIAS  = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/requant_sat_relu.sv
`default_nettype none
// requant_sat_relu -- floor arithmetic shift, saturate to the signed data range, optional ReLU.
// rev 1.0
module requant_sat_relu
  import nn_pkg::*;
#(
  parameter int ACC_BITS   = DEF_ACC_BITS,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int SHIFT_BITS = DEF_SHIFT_BITS
) (
  input  logic signed [ACC_BITS-1:0]   acc_val,
  input  logic        [SHIFT_BITS-1:0] shift,
  input  logic                         relu_en,
  output logic signed [DATA_BITS-1:0]  result
);

  localparam logic signed [ACC_BITS-1:0] MAX_VAL = ACC_BITS'((2 ** (DATA_BITS - 1)) - 1);
  localparam logic signed [ACC_BITS-1:0] MIN_VAL = ~MAX_VAL;

  logic signed [ACC_BITS-1:0] shifted;

  always_comb begin
    shifted = acc_val >>> shift;
    if (shifted > MAX_VAL)
      result = DATA_BITS'(MAX_VAL);
    else if (shifted < MIN_VAL)
      result = DATA_BITS'(MIN_VAL);
    else
      result = DATA_BITS'(shifted);
    if (relu_en && result[DATA_BITS-1])
      result = '0;
  end

endmodule
`default_nettype wire

// File: rtl/dense_lane_engine.sv
`default_nettype none
// dense_lane_engine -- LANES-wide dense layer: bias load, MAC over k, requantised write-back.
// rev 1.0
module dense_lane_engine
  import nn_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int ACC_BITS   = DEF_ACC_BITS,
  parameter int LANES      = DEF_LANES,
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int SIZE_BITS  = DEF_SIZE_BITS,
  parameter int SHIFT_BITS = DEF_SHIFT_BITS
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       start_in,
  input  logic [SIZE_BITS-1:0]       m_size_in,
  input  logic [SIZE_BITS-1:0]       k_size_in,
  input  logic [SHIFT_BITS-1:0]      shift_in,
  input  logic                       relu_en_in,
  input  logic [ADDR_BITS-1:0]       input_base_in,
  input  logic [ADDR_BITS-1:0]       weight_base_in,
  input  logic [ADDR_BITS-1:0]       bias_base_in,
  input  logic [ADDR_BITS-1:0]       output_base_in,
  output logic                       busy_out,
  output logic                       done_out,
  output logic                       in_rd_en_out,
  output logic [ADDR_BITS-1:0]       in_rd_addr_out,
  input  logic [DATA_BITS-1:0]       in_rd_data_in,
  output logic                       w_rd_en_out,
  output logic [ADDR_BITS-1:0]       w_rd_addr_out,
  input  logic [LANES*DATA_BITS-1:0] w_rd_data_in,
  output logic                       b_rd_en_out,
  output logic [ADDR_BITS-1:0]       b_rd_addr_out,
  input  logic [LANES*DATA_BITS-1:0] b_rd_data_in,
  output logic                       out_wr_en_out,
  output logic [ADDR_BITS-1:0]       out_wr_addr_out,
  output logic [DATA_BITS-1:0]       out_wr_data_out
);

  localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [SIZE_BITS-1:0] LANES_SZ = SIZE_BITS'(LANES);
  localparam logic [SIZE_BITS-1:0] ONE_SZ   = SIZE_BITS'(1);
  localparam logic [ADDR_BITS-1:0] ONE_ADDR = ADDR_BITS'(1);
  localparam logic [LANE_BITS-1:0] ONE_LANE = LANE_BITS'(1);

  state_t                  state;
  logic [SIZE_BITS-1:0]    remaining;
  logic [SIZE_BITS-1:0]    k_idx;
  logic [SIZE_BITS-1:0]    cfg_k_size;
  logic [SHIFT_BITS-1:0]   cfg_shift;
  logic                    cfg_relu;
  logic [ADDR_BITS-1:0]    cfg_input_base;
  logic [ADDR_BITS-1:0]    bias_ptr;
  logic [ADDR_BITS-1:0]    w_grp;
  logic [ADDR_BITS-1:0]    out_grp;
  logic [LANE_BITS-1:0]    lane;
  logic                    bias_pend;
  logic                    mac_pend;

  logic signed [ACC_BITS-1:0]    acc [LANES];
  logic signed [DATA_BITS-1:0]   in_val;
  logic signed [DATA_BITS-1:0]   bias_lane [LANES];
  logic signed [DATA_BITS-1:0]   w_lane [LANES];
  logic signed [2*DATA_BITS-1:0] prod [LANES];

  logic [SIZE_BITS-1:0]        valid_lanes;
  logic                        last_lane;
  logic                        last_group;
  logic signed [ACC_BITS-1:0]  acc_sel;
  logic signed [DATA_BITS-1:0] requant_val;

  always_comb begin
    in_val = in_rd_data_in;
    for (int l = 0; l < LANES; l++) begin
      bias_lane[l] = b_rd_data_in[l*DATA_BITS +: DATA_BITS];
      w_lane[l]    = w_rd_data_in[l*DATA_BITS +: DATA_BITS];
      prod[l]      = (2*DATA_BITS)'(in_val) * (2*DATA_BITS)'(w_lane[l]);
    end
  end

  assign valid_lanes = (remaining >= LANES_SZ) ? LANES_SZ : remaining;
  assign last_lane   = ((SIZE_BITS'(lane) + ONE_SZ) == valid_lanes);
  assign last_group  = (remaining <= LANES_SZ);
  assign acc_sel     = acc[lane];

  requant_sat_relu #(
    .ACC_BITS   (ACC_BITS),
    .DATA_BITS  (DATA_BITS),
    .SHIFT_BITS (SHIFT_BITS)
  ) u_requant (
    .acc_val (acc_sel),
    .shift   (cfg_shift),
    .relu_en (cfg_relu),
    .result  (requant_val)
  );

  // Read returns are tracked by delayed enables, so the accumulators follow the
  // memory pipeline rather than the FSM state.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bias_pend <= 1'b0;
      mac_pend  <= 1'b0;
      for (int l = 0; l < LANES; l++)
        acc[l] <= '0;
    end else begin
      bias_pend <= b_rd_en_out;
      mac_pend  <= in_rd_en_out;
      for (int l = 0; l < LANES; l++) begin
        if (bias_pend)
          acc[l] <= ACC_BITS'(bias_lane[l]);
        else if (mac_pend)
          acc[l] <= acc[l] + ACC_BITS'(prod[l]);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= ST_IDLE;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      in_rd_en_out    <= 1'b0;
      in_rd_addr_out  <= '0;
      w_rd_en_out     <= 1'b0;
      w_rd_addr_out   <= '0;
      b_rd_en_out     <= 1'b0;
      b_rd_addr_out   <= '0;
      out_wr_en_out   <= 1'b0;
      out_wr_addr_out <= '0;
      out_wr_data_out <= '0;
      remaining       <= '0;
      k_idx           <= '0;
      cfg_k_size      <= '0;
      cfg_shift       <= '0;
      cfg_relu        <= 1'b0;
      cfg_input_base  <= '0;
      bias_ptr        <= '0;
      w_grp           <= '0;
      out_grp         <= '0;
      lane            <= '0;
    end else begin
      in_rd_en_out  <= 1'b0;
      w_rd_en_out   <= 1'b0;
      b_rd_en_out   <= 1'b0;
      out_wr_en_out <= 1'b0;
      done_out      <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy_out <= 1'b0;
          if (start_in) begin
            busy_out       <= 1'b1;
            remaining      <= m_size_in;
            cfg_k_size     <= k_size_in;
            cfg_shift      <= shift_in;
            cfg_relu       <= relu_en_in;
            cfg_input_base <= input_base_in;
            bias_ptr       <= bias_base_in;
            w_grp          <= weight_base_in;
            out_grp        <= output_base_in;
            if (m_size_in == '0) begin
              state <= ST_DONE;
            end else begin
              state         <= ST_BIAS;
              b_rd_en_out   <= 1'b1;
              b_rd_addr_out <= bias_base_in;
            end
          end
        end
        ST_BIAS: begin
          if (cfg_k_size != '0) begin
            state          <= ST_MAC;
            in_rd_en_out   <= 1'b1;
            in_rd_addr_out <= cfg_input_base;
            w_rd_en_out    <= 1'b1;
            w_rd_addr_out  <= w_grp;
            k_idx          <= ONE_SZ;
          end else begin
            state <= ST_DRAIN;
          end
        end
        ST_MAC: begin
          if (k_idx == cfg_k_size) begin
            state <= ST_DRAIN;
          end else begin
            in_rd_en_out   <= 1'b1;
            in_rd_addr_out <= cfg_input_base + ADDR_BITS'(k_idx);
            w_rd_en_out    <= 1'b1;
            w_rd_addr_out  <= w_grp + ADDR_BITS'(k_idx);
            k_idx          <= k_idx + ONE_SZ;
          end
        end
        ST_DRAIN: begin
          state <= ST_WRITE;
          lane  <= '0;
        end
        ST_WRITE: begin
          // Write port is registered: lane l appears on the port one cycle after its WRITE cycle.
          out_wr_en_out   <= 1'b1;
          out_wr_addr_out <= out_grp + ADDR_BITS'(lane);
          out_wr_data_out <= requant_val;
          if (last_lane) begin
            if (last_group) begin
              state <= ST_DONE;
            end else begin
              state         <= ST_BIAS;
              remaining     <= remaining - LANES_SZ;
              bias_ptr      <= bias_ptr + ONE_ADDR;
              b_rd_en_out   <= 1'b1;
              b_rd_addr_out <= bias_ptr + ONE_ADDR;
              w_grp         <= w_grp + ADDR_BITS'(cfg_k_size);
              out_grp       <= out_grp + ADDR_BITS'(LANES);
            end
          end else begin
            lane <= lane + ONE_LANE;
          end
        end
        ST_DONE: begin
          done_out <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
